// File: rtl/m_7seg_scan_ctrl_pkg.sv
// Shared types, default constants and the leading-zero blanking helper
// for the 7-segment scan controller.
package m_7seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam int MAX_DIGITS    = 8;
  localparam int DEF_N_DIGITS  = 4;
  localparam int DEF_PRESCALE  = 50000;
  localparam int DEF_BLANK_CYC = 500;

  // Bit i set when digit i and every digit above it hold zero; digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(input logic [4*MAX_DIGITS-1:0] disp,
                                                      input int n_digits);
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n_digits) begin
        zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
        mask[i]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/m_7seg_scan_ctrl_if.sv
// Host/display bundle of the scan controller; master is the host side,
// slave is the controller.
interface m_7seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*N_DIGITS-1:0]   data;
  logic                    lzb;
  logic [3:0]              code;
  logic                    en;
  logic [N_DIGITS-1:0]     an;
  logic                    pending;
  logic                    frame;

  modport master (
    output enable, load, data, lzb,
    input  code, en, an, pending, frame
  );

  modport slave (
    input  enable, load, data, lzb,
    output code, en, an, pending, frame
  );
endinterface

// File: rtl/m_7seg_scan_ctrl_tick.sv
// Slot timebase: counts cycles within a digit slot and walks the digit index,
// flagging blank end, slot end and frame end.
module m_scan_tick #(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500,
  localparam int CNT_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1,
  localparam int IDX_W    = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             run,
  output logic [IDX_W-1:0] idx,
  output logic             slot_end,
  output logic             blank_done,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;

  assign idx       = idx_reg;
  assign slot_end  = run && (cnt_reg == CNT_W'(PRESCALE - 1));
  assign frame_end = slot_end && (idx_reg == IDX_W'(N_DIGITS - 1));

  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign blank_done = run && (cnt_reg == CNT_W'(BLANK_CYC - 1));
    end else begin : g_no_blank
      assign blank_done = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (run) begin
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_7seg_scan_ctrl.sv
// Time-multiplexed scan controller for N common-anode digits sharing one
// hex decoder, with blanking gaps, leading-zero blanking and frame-aligned loads.
module m_7seg_scan_ctrl
  import m_7seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  m_7seg_scan_ctrl_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;
  localparam scan_state_e SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

  scan_state_e           state_reg, state_next;
  logic [DW-1:0]         display_reg, pending_data_reg;
  logic                  pending_reg;
  logic [3:0]            code_reg;
  logic                  en_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic                  frame_reg;

  logic                  tick_clr, tick_run, apply_idle;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end, blank_done, frame_end;

  m_scan_tick #(
    .N_DIGITS  (N_DIGITS),
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk        (I_CLK),
    .srst       (I_RST),
    .clr        (tick_clr),
    .run        (tick_run),
    .idx        (idx),
    .slot_end   (slot_end),
    .blank_done (blank_done),
    .frame_end  (frame_end)
  );

  always_comb begin
    state_next = state_reg;
    tick_clr   = 1'b0;
    tick_run   = 1'b0;
    apply_idle = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_clr = 1'b1;
        if (bus.enable) begin
          apply_idle = 1'b1;
          state_next = SLOT_START;
        end
      end
      BLANK, SHOW: begin
        if (!bus.enable) begin
          tick_clr   = 1'b1;
          state_next = IDLE;
        end else begin
          tick_run = 1'b1;
          if (slot_end)
            state_next = SLOT_START;
          else if (blank_done)
            state_next = SHOW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // A load landing on the boundary cycle stays pending; only the older value is applied.
  logic take_pending;
  assign take_pending = pending_reg && (apply_idle || frame_end);

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      display_reg      <= '0;
      pending_data_reg <= '0;
      pending_reg      <= 1'b0;
    end else begin
      if (take_pending)
        display_reg <= pending_data_reg;
      if (bus.load) begin
        pending_data_reg <= bus.data;
        pending_reg      <= 1'b1;
      end else if (take_pending) begin
        pending_reg <= 1'b0;
      end
    end
  end

  logic [4*MAX_DIGITS-1:0] disp_ext;
  logic [MAX_DIGITS-1:0]   blank_mask;
  logic [3:0]              nibble;
  logic                    digit_blanked;
  logic [N_DIGITS-1:0]     an_onehot;

  assign disp_ext      = (4*MAX_DIGITS)'(display_reg);
  assign blank_mask    = lzb_mask(disp_ext, N_DIGITS);
  assign nibble        = display_reg[{idx, 2'b00} +: 4];
  assign digit_blanked = bus.lzb && blank_mask[idx];
  assign an_onehot     = N_DIGITS'(1) << idx;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      code_reg  <= '0;
      en_reg    <= 1'b0;
      an_reg    <= '0;
      frame_reg <= 1'b0;
    end else begin
      code_reg  <= '0;
      en_reg    <= 1'b0;
      an_reg    <= '0;
      frame_reg <= frame_end;
      if (bus.enable) begin
        case (state_reg)
          BLANK: code_reg <= nibble;
          SHOW: begin
            code_reg <= nibble;
            an_reg   <= digit_blanked ? '0 : an_onehot;
            en_reg   <= !digit_blanked;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.code    = code_reg;
  assign bus.en      = en_reg;
  assign bus.an      = an_reg;
  assign bus.frame   = frame_reg;
  assign bus.pending = pending_reg;

endmodule

// File: tb/tb_m_7seg_scan_ctrl.sv
// Directed bench for m_7seg_scan_ctrl with N_DIGITS=4, PRESCALE=8, BLANK_CYC=2.
module tb_m_7seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m_7seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  m_7seg_scan_ctrl #(
    .N_DIGITS  (4),
    .PRESCALE  (8),
    .BLANK_CYC (2)
  ) dut (
    .I_CLK (clk),
    .I_RST (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] P_NONE = 8'h00;
  localparam logic [7:0] P_LOAD = 8'hFE;
  localparam logic [7:0] P_ALL  = 8'hFF;
  localparam logic [7:0] P_LAST = 8'h7F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " an"}, 32'(bus.an), 32'd0);
    chk({tag, " en"}, 32'(bus.en), 32'd0);
    chk({tag, " code"}, 32'(bus.code), 32'd0);
    chk({tag, " frame"}, 32'(bus.frame), 32'd0);
  endtask

  // Entered at the first sample of a slot; leaves at the first sample of the next slot.
  task automatic chk_slot(input string tag, input logic [3:0] an_exp, input logic [3:0] code_exp,
                          input logic en_exp, input bit last, input logic [7:0] pend_mask);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s c%0d an", tag, c), 32'(bus.an), (c < 2) ? 32'd0 : 32'(an_exp));
      chk($sformatf("%s c%0d en", tag, c), 32'(bus.en), (c < 2) ? 32'd0 : 32'(en_exp));
      chk($sformatf("%s c%0d code", tag, c), 32'(bus.code), 32'(code_exp));
      chk($sformatf("%s c%0d frame", tag, c), 32'(bus.frame), 32'(last && c == 7));
      chk($sformatf("%s c%0d pend", tag, c), 32'(bus.pending), 32'(pend_mask[c]));
      step();
      bus.load = 1'b0;
    end
    $display("slot %s: an=%b code=%0h en=%b", tag, an_exp, code_exp, en_exp);
  endtask

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.data   = '0;
    bus.lzb    = 1'b0;

    // 1: reset then idle
    for (int i = 0; i < 3; i++) step();
    chk_idle("rst");
    chk("rst pend", 32'(bus.pending), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle("idle");
      chk("idle pend", 32'(bus.pending), 32'd0);
    end
    $display("reset/idle: 20 cycles checked");

    // 2: load 0x1234 while idle, then enable
    bus.load = 1'b1;
    bus.data = 16'h1234;
    step();
    bus.load = 1'b0;
    chk("ld pend", 32'(bus.pending), 32'd1);
    bus.enable = 1'b1;
    step();
    chk_idle("en0");
    chk("en0 pend", 32'(bus.pending), 32'd0);
    step();
    for (int f = 0; f < 2; f++) begin
      chk_slot("f1 d0", 4'b0001, 4'h4, 1'b1, 1'b0, P_NONE);
      chk_slot("f1 d1", 4'b0010, 4'h3, 1'b1, 1'b0, P_NONE);
      chk_slot("f1 d2", 4'b0100, 4'h2, 1'b1, 1'b0, P_NONE);
      chk_slot("f1 d3", 4'b1000, 4'h1, 1'b1, 1'b1, P_NONE);
    end

    // 3: load 0x0050 with leading-zero blanking
    bus.lzb  = 1'b1;
    bus.load = 1'b1;
    bus.data = 16'h0050;
    chk_slot("f3 d0", 4'b0001, 4'h4, 1'b1, 1'b0, P_LOAD);
    chk_slot("f3 d1", 4'b0010, 4'h3, 1'b1, 1'b0, P_ALL);
    chk_slot("f3 d2", 4'b0100, 4'h2, 1'b1, 1'b0, P_ALL);
    chk_slot("f3 d3", 4'b1000, 4'h1, 1'b1, 1'b1, P_LAST);
    chk_slot("f4 d0", 4'b0001, 4'h0, 1'b1, 1'b0, P_NONE);
    chk_slot("f4 d1", 4'b0010, 4'h5, 1'b1, 1'b0, P_NONE);
    chk_slot("f4 d2", 4'b0000, 4'h0, 1'b0, 1'b0, P_NONE);
    chk_slot("f4 d3", 4'b0000, 4'h0, 1'b0, 1'b1, P_NONE);
    bus.lzb  = 1'b0;
    bus.load = 1'b1;
    bus.data = 16'h1234;
    chk_slot("f5 d0", 4'b0001, 4'h0, 1'b1, 1'b0, P_LOAD);
    chk_slot("f5 d1", 4'b0010, 4'h5, 1'b1, 1'b0, P_ALL);
    chk_slot("f5 d2", 4'b0100, 4'h0, 1'b1, 1'b0, P_ALL);
    chk_slot("f5 d3", 4'b1000, 4'h0, 1'b1, 1'b1, P_LAST);

    // 4: two loads in one frame, latest wins
    bus.load = 1'b1;
    bus.data = 16'h1111;
    chk_slot("f6 d0", 4'b0001, 4'h4, 1'b1, 1'b0, P_LOAD);
    chk_slot("f6 d1", 4'b0010, 4'h3, 1'b1, 1'b0, P_ALL);
    bus.load = 1'b1;
    bus.data = 16'h2222;
    chk_slot("f6 d2", 4'b0100, 4'h2, 1'b1, 1'b0, P_ALL);
    chk_slot("f6 d3", 4'b1000, 4'h1, 1'b1, 1'b1, P_LAST);
    chk_slot("f7 d0", 4'b0001, 4'h2, 1'b1, 1'b0, P_NONE);
    chk_slot("f7 d1", 4'b0010, 4'h2, 1'b1, 1'b0, P_NONE);
    chk_slot("f7 d2", 4'b0100, 4'h2, 1'b1, 1'b0, P_NONE);
    chk_slot("f7 d3", 4'b1000, 4'h2, 1'b1, 1'b1, P_NONE);

    // 5: drop enable in cycle 4 of the digit-2 slot, then restart
    chk_slot("f8 d0", 4'b0001, 4'h2, 1'b1, 1'b0, P_NONE);
    chk_slot("f8 d1", 4'b0010, 4'h2, 1'b1, 1'b0, P_NONE);
    for (int i = 0; i < 4; i++) step();
    chk("d2c4 an", 32'(bus.an), 32'b0100);
    chk("d2c4 en", 32'(bus.en), 32'd1);
    chk("d2c4 code", 32'(bus.code), 32'h2);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("dis");
    end
    $display("disable: outputs idle for 4 cycles");
    bus.enable = 1'b1;
    step();
    chk_idle("reen");
    step();
    chk_slot("f9 d0", 4'b0001, 4'h2, 1'b1, 1'b0, P_NONE);
    chk_slot("f9 d1", 4'b0010, 4'h2, 1'b1, 1'b0, P_NONE);

    // 6: reset mid-SHOW with a load pending, reset and load together
    bus.load = 1'b1;
    bus.data = 16'h9999;
    step();
    bus.load = 1'b0;
    step();
    step();
    chk("pre-rst pend", 32'(bus.pending), 32'd1);
    chk("pre-rst an", 32'(bus.an), 32'b0100);
    rst        = 1'b1;
    bus.load   = 1'b1;
    bus.data   = 16'h7777;
    bus.enable = 1'b0;
    step();
    rst      = 1'b0;
    bus.load = 1'b0;
    chk_idle("rst2");
    chk("rst2 pend", 32'(bus.pending), 32'd0);
    step();
    chk_idle("rst2b");
    chk("rst2b pend", 32'(bus.pending), 32'd0);
    $display("mid-scan reset: outputs and pending cleared");
    bus.enable = 1'b1;
    step();
    chk_idle("reen2");
    step();
    chk_slot("f10 d0", 4'b0001, 4'h0, 1'b1, 1'b0, P_NONE);
    chk_slot("f10 d1", 4'b0010, 4'h0, 1'b1, 1'b0, P_NONE);
    chk_slot("f10 d2", 4'b0100, 4'h0, 1'b1, 1'b0, P_NONE);
    chk_slot("f10 d3", 4'b1000, 4'h0, 1'b1, 1'b1, P_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
